// File: rtl/kernel_pr_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module : kernel_pr_accum_pkg
// Brief  : Shared constants for the PageRank vertex accumulator.
// Rev    : 1.0
// ============================================================================
package kernel_pr_accum_pkg;

    localparam int ID_W    = 32;
    localparam int VAL_W   = 32;
    localparam int DATA_W  = ID_W + VAL_W;

    localparam int ID_MSB  = DATA_W - 1;
    localparam int ID_LSB  = VAL_W;
    localparam int VAL_MSB = VAL_W - 1;
    localparam int VAL_LSB = 0;

    localparam logic [ID_W-1:0] EOS_ID = '1;

    typedef logic [0:0] state_t;
    localparam state_t ST_RUN   = 1'b0;
    localparam state_t ST_FLUSH = 1'b1;

endpackage
`default_nettype wire

// File: rtl/kernel_pr_sat_add.sv
`default_nettype none
// ============================================================================
// Module : kernel_pr_sat_add
// Brief  : Unsigned saturating adder; clamps to all-ones and flags overflow.
// Rev    : 1.0
// ============================================================================
module kernel_pr_sat_add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ovf_o
);

    logic [WIDTH:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i};
    assign ovf_o    = full_sum[WIDTH];
    assign sum_o    = ovf_o ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/kernel_pr_vtx_accum.sv
`default_nettype none
// ============================================================================
// Module : kernel_pr_vtx_accum
// Brief  : Sums contributions of consecutive same-vertex records; forwards EOS.
// Rev    : 1.0
// ============================================================================
module kernel_pr_vtx_accum
    import kernel_pr_accum_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 32,
    parameter int VAL_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_empty_n,
    input  logic [DATA_WIDTH-1:0] in_dout,
    output logic                  in_read,
    input  logic                  out_full_n,
    output logic                  out_write,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  idle,
    output logic                  sat_seen,
    output logic [31:0]           run_count
);

    localparam logic [ID_WIDTH-1:0]   C_EOS_ID  = '1;
    localparam logic [DATA_WIDTH-1:0] C_EOS_REC = {C_EOS_ID, {VAL_WIDTH{1'b0}}};

    state_t                  state_q, state_d;
    logic                    run_valid_q, run_valid_d;
    logic [ID_WIDTH-1:0]     cur_id_q, cur_id_d;
    logic [VAL_WIDTH-1:0]    cur_sum_q, cur_sum_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    sat_seen_q, sat_seen_d;
    logic [31:0]             run_count_q, run_count_d;

    logic [ID_WIDTH-1:0]     in_id;
    logic [VAL_WIDTH-1:0]    in_val;
    logic                    in_eos;
    logic                    slot_ok;
    logic                    drain;
    logic                    rd_en;
    logic                    flush_go;
    logic                    load;
    logic [DATA_WIDTH-1:0]   load_data;
    logic [VAL_WIDTH-1:0]    acc_sum;
    logic                    acc_ovf;

    assign in_id   = in_dout[DATA_WIDTH-1 -: ID_WIDTH];
    assign in_val  = in_dout[VAL_WIDTH-1:0];
    assign in_eos  = (in_id == C_EOS_ID);
    assign slot_ok = ~out_valid_q | out_full_n;
    assign drain   = out_valid_q & out_full_n;

    kernel_pr_sat_add #(
        .WIDTH (VAL_WIDTH)
    ) u_sat_add (
        .a_i   (cur_sum_q),
        .b_i   (in_val),
        .sum_o (acc_sum),
        .ovf_o (acc_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (rd_en && in_eos && run_valid_q) state_d = ST_FLUSH;
            ST_FLUSH: if (slot_ok) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        rd_en    = 1'b0;
        flush_go = 1'b0;
        case (state_q)
            ST_RUN:   rd_en    = ~reset & in_empty_n & slot_ok;
            ST_FLUSH: flush_go = slot_ok;
            default:  ;
        endcase
        idle = (state_q == ST_RUN) & ~run_valid_q & ~out_valid_q;
    end

    always_comb begin
        run_valid_d = run_valid_q;
        cur_id_d    = cur_id_q;
        cur_sum_d   = cur_sum_q;
        sat_seen_d  = sat_seen_q;
        load        = 1'b0;
        load_data   = '0;
        if (rd_en) begin
            if (in_eos) begin
                load = 1'b1;
                if (run_valid_q) begin
                    load_data   = {cur_id_q, cur_sum_q};
                    run_valid_d = 1'b0;
                end else begin
                    load_data = C_EOS_REC;
                end
            end else if (run_valid_q && (in_id == cur_id_q)) begin
                cur_sum_d  = acc_sum;
                sat_seen_d = sat_seen_q | acc_ovf;
            end else begin
                if (run_valid_q) begin
                    load      = 1'b1;
                    load_data = {cur_id_q, cur_sum_q};
                end
                cur_id_d    = in_id;
                cur_sum_d   = in_val;
                run_valid_d = 1'b1;
            end
        end else if (flush_go) begin
            load      = 1'b1;
            load_data = C_EOS_REC;
        end
        // A same-cycle load overrides the drain so the slot never empties between records.
        out_valid_d = load | (out_valid_q & ~drain);
        out_data_d  = load ? load_data : out_data_q;
        run_count_d = run_count_q
                    + 32'((drain && (out_data_q[DATA_WIDTH-1 -: ID_WIDTH] != C_EOS_ID)) ? 1 : 0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_valid_q <= 1'b0;
            cur_id_q    <= '0;
            cur_sum_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_seen_q  <= 1'b0;
            run_count_q <= '0;
        end else begin
            run_valid_q <= run_valid_d;
            cur_id_q    <= cur_id_d;
            cur_sum_q   <= cur_sum_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_seen_q  <= sat_seen_d;
            run_count_q <= run_count_d;
        end
    end

    assign in_read   = rd_en;
    assign out_write = out_valid_q;
    assign out_din   = out_data_q;
    assign sat_seen  = sat_seen_q;
    assign run_count = run_count_q;

endmodule
`default_nettype wire

// File: tb/tb_kernel_pr_vtx_accum.sv
`default_nettype none
// ============================================================================
// Module : tb_kernel_pr_vtx_accum
// Brief  : Self-checking bench: vector table, corner sequences, random stream.
// Rev    : 1.0
// ============================================================================
module tb_kernel_pr_vtx_accum;

    localparam logic [31:0] EOS = 32'hFFFF_FFFF;
    localparam int          NV  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_empty_n;
    logic [63:0] in_dout;
    logic        in_read;
    logic        out_full_n;
    logic        out_write;
    logic [63:0] out_din;
    logic        idle;
    logic        sat_seen;
    logic [31:0] run_count;

    always #5 clk = ~clk;

    kernel_pr_vtx_accum u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_empty_n (in_empty_n),
        .in_dout    (in_dout),
        .in_read    (in_read),
        .out_full_n (out_full_n),
        .out_write  (out_write),
        .out_din    (out_din),
        .idle       (idle),
        .sat_seen   (sat_seen),
        .run_count  (run_count)
    );

    typedef struct {
        int               n_in;
        logic [5:0][63:0] ins;
        int               n_out;
        logic [5:0][63:0] outs;
        int               rc_delta;
        bit               sat;
    } vec_t;

    vec_t        vec [NV];
    logic [63:0] src_q  [$];
    logic [63:0] got_q  [$];
    logic [63:0] exp_q  [$];
    logic [63:0] stim_q [$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_rc   = 0;
    bit          m_sat;
    logic        snap_in_read, snap_out_write;
    logic [63:0] snap_out_din;

    function automatic logic [63:0] rec(input logic [31:0] id, input logic [31:0] val);
        return {id, val};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; drives inputs, samples on the falling edge.
    task automatic cycle(input bit en_in, input bit en_out);
        in_empty_n = en_in && (src_q.size() > 0);
        in_dout    = (src_q.size() > 0) ? src_q[0] : 64'h0;
        out_full_n = en_out;
        @(negedge clk);
        snap_in_read   = in_read;
        snap_out_write = out_write;
        snap_out_din   = out_din;
        if (in_read && src_q.size() > 0) void'(src_q.pop_front());
        if (out_write && out_full_n) got_q.push_back(out_din);
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int budget, input bit rnd);
        int n = 0;
        while ((src_q.size() > 0 || !idle) && n < budget) begin
            if (rnd) cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
            else     cycle(1'b1, 1'b1);
            n++;
        end
        check("drain_budget", 64'(n >= budget), 64'd0);
    endtask

    task automatic compare_out(input string tag);
        int bad = 0;
        check({tag, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size() && bad < 5; i++) begin
            if (got_q[i] !== exp_q[i]) bad++;
            check($sformatf("%s rec%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    // Reference: group adjacent equal ids, saturating sum, EOS closes run then forwards.
    task automatic build_expected();
        bit          open = 0;
        logic [31:0] id   = 0;
        longint unsigned sum = 0;
        exp_q.delete();
        m_sat = 0;
        foreach (stim_q[i]) begin
            logic [31:0] nid;
            logic [31:0] v;
            nid = stim_q[i][63:32];
            v   = stim_q[i][31:0];
            if (nid == EOS) begin
                if (open) exp_q.push_back({id, sum[31:0]});
                exp_q.push_back({EOS, 32'h0});
                open = 0;
            end else if (open && nid == id) begin
                sum = sum + 64'(v);
                if (sum > 64'hFFFF_FFFF) begin
                    sum   = 64'hFFFF_FFFF;
                    m_sat = 1;
                end
            end else begin
                if (open) exp_q.push_back({id, sum[31:0]});
                id   = nid;
                sum  = 64'(v);
                open = 1;
            end
        end
    endtask

    task automatic vin(input int v, input logic [31:0] id, input logic [31:0] val);
        vec[v].ins[vec[v].n_in] = rec(id, val);
        vec[v].n_in++;
    endtask

    task automatic vout(input int v, input logic [31:0] id, input logic [31:0] val);
        vec[v].outs[vec[v].n_out] = rec(id, val);
        vec[v].n_out++;
    endtask

    initial begin
        for (int v = 0; v < NV; v++) begin
            vec[v].n_in = 0; vec[v].n_out = 0; vec[v].ins = '0; vec[v].outs = '0;
        end
        vin(0, 5, 10); vin(0, 5, 20); vin(0, 7, 1); vin(0, EOS, 0);
        vout(0, 5, 30); vout(0, 7, 1); vout(0, EOS, 0);
        vec[0].rc_delta = 2; vec[0].sat = 0;
        vin(1, 3, 32'hFFFF_FFF0); vin(1, 3, 32'h20); vin(1, EOS, 0);
        vout(1, 3, 32'hFFFF_FFFF); vout(1, EOS, 0);
        vec[1].rc_delta = 1; vec[1].sat = 1;
        vin(2, EOS, 0);
        vout(2, EOS, 0);
        vec[2].rc_delta = 0; vec[2].sat = 1;
        vin(3, 8, 5); vin(3, 9, 6); vin(3, 9, 7); vin(3, 8, 1); vin(3, EOS, 0);
        vout(3, 8, 5); vout(3, 9, 13); vout(3, 8, 1); vout(3, EOS, 0);
        vec[3].rc_delta = 3; vec[3].sat = 1;

        reset = 1'b1; in_empty_n = 1'b0; in_dout = '0; out_full_n = 1'b1;
        @(posedge clk); #1;
        src_q.push_back(rec(EOS, 0));
        cycle(1'b1, 1'b1);
        check("rst in_read", 64'(snap_in_read), 64'd0);
        check("rst out_write", 64'(out_write), 64'd0);
        check("rst out_din", out_din, 64'h0);
        check("rst idle", 64'(idle), 64'd1);
        check("rst sat_seen", 64'(sat_seen), 64'd0);
        check("rst run_count", 64'(run_count), 64'd0);
        src_q.delete();
        reset = 1'b0;

        for (int v = 0; v < NV; v++) begin
            got_q.delete(); exp_q.delete();
            for (int k = 0; k < vec[v].n_in; k++) src_q.push_back(vec[v].ins[k]);
            for (int k = 0; k < vec[v].n_out; k++) exp_q.push_back(vec[v].outs[k]);
            run_until_idle(200, 1'b0);
            compare_out($sformatf("vec%0d", v));
            exp_rc += 32'(vec[v].rc_delta);
            check($sformatf("vec%0d run_count", v), 64'(run_count), 64'(exp_rc));
            check($sformatf("vec%0d sat_seen", v), 64'(sat_seen), 64'(vec[v].sat));
            check($sformatf("vec%0d idle", v), 64'(idle), 64'd1);
        end

        // EOS closing an open run: result one cycle after the pop, marker the next.
        got_q.delete();
        src_q.push_back(rec(4, 2)); src_q.push_back(rec(EOS, 0));
        cycle(1'b1, 1'b1);
        check("lat rd0", 64'(snap_in_read), 64'd1);
        cycle(1'b1, 1'b1);
        check("lat rd1", 64'(snap_in_read), 64'd1);
        check("lat wr1", 64'(snap_out_write), 64'd0);
        cycle(1'b1, 1'b1);
        check("lat flush rd", 64'(snap_in_read), 64'd0);
        check("lat result", snap_out_din, rec(4, 2));
        check("lat result wr", 64'(snap_out_write), 64'd1);
        cycle(1'b1, 1'b1);
        check("lat eos", snap_out_din, rec(EOS, 0));
        check("lat eos wr", 64'(snap_out_write), 64'd1);
        check("lat idle", 64'(idle), 64'd1);
        exp_rc += 1;

        // Backpressure: hold first pushed record for three cycles.
        got_q.delete();
        src_q.push_back(rec(1, 1)); src_q.push_back(rec(2, 2));
        src_q.push_back(rec(3, 3)); src_q.push_back(rec(EOS, 0));
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        for (int s = 0; s < 3; s++) begin
            cycle(1'b1, 1'b0);
            check($sformatf("bp hold%0d", s), snap_out_din, rec(1, 1));
            check($sformatf("bp wr%0d", s), 64'(snap_out_write), 64'd1);
            check($sformatf("bp rd%0d", s), 64'(snap_in_read), 64'd0);
        end
        run_until_idle(200, 1'b0);
        exp_q.delete();
        exp_q.push_back(rec(1, 1)); exp_q.push_back(rec(2, 2));
        exp_q.push_back(rec(3, 3)); exp_q.push_back(rec(EOS, 0));
        compare_out("bp");
        exp_rc += 3;
        check("bp run_count", 64'(run_count), 64'(exp_rc));

        // Reset mid-run discards the open run.
        got_q.delete();
        src_q.push_back(rec(9, 4)); src_q.push_back(rec(9, 4)); src_q.push_back(rec(EOS, 0));
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        reset = 1'b1;
        cycle(1'b1, 1'b1);
        check("mrst in_read", 64'(snap_in_read), 64'd0);
        check("mrst out_write", 64'(out_write), 64'd0);
        check("mrst out_din", out_din, 64'h0);
        check("mrst idle", 64'(idle), 64'd1);
        check("mrst sat_seen", 64'(sat_seen), 64'd0);
        check("mrst run_count", 64'(run_count), 64'd0);
        reset = 1'b0;
        run_until_idle(200, 1'b0);
        exp_q.delete();
        exp_q.push_back(rec(EOS, 0));
        compare_out("mrst");
        check("mrst run_count end", 64'(run_count), 64'd0);
        exp_rc = 0;

        // Random stream with random handshakes against the reference model.
        got_q.delete();
        stim_q.delete();
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] id;
            logic [31:0] val;
            id  = ($urandom_range(0, 15) == 0) ? EOS : 32'($urandom_range(0, 3));
            val = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1000));
            stim_q.push_back(rec(id, val));
        end
        stim_q.push_back(rec(EOS, 0));
        build_expected();
        src_q = stim_q;
        run_until_idle(60000, 1'b1);
        compare_out("rand");
        exp_rc = 0;
        foreach (exp_q[i]) if (exp_q[i][63:32] != EOS) exp_rc++;
        check("rand run_count", 64'(run_count), 64'(exp_rc));
        check("rand sat_seen", 64'(sat_seen), 64'(m_sat));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
